// File: rtl/ad9361_samp_gate_pkg.sv
// Shared types, constants and width helpers for the AD9361 energy-gated sample filter.
package ad9361_samp_gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HANG = 2'd2
  } gate_state_t;

  // Cycles from a sample entering the block to the gate FSM reacting to it.
  localparam int DET_LAT = 3;

  function automatic int mag_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int sum_width(input int data_width, input int log2_len);
    return data_width + 1 + log2_len;
  endfunction

endpackage

// File: rtl/ad9361_samp_gate_det.sv
// Per-channel energy detector: |I|+|Q| magnitude, power-of-two boxcar average and
// hysteresis threshold compares.
module ad9361_samp_gate_det
  import ad9361_samp_gate_pkg::*;
#(
  parameter int DATA_WIDTH         = 12,
  parameter int LOG2_FILTER_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] data_q,
  input  logic [DATA_WIDTH-1:0] thresh_on,
  input  logic [DATA_WIDTH-1:0] thresh_off,
  output logic                  above,
  output logic                  below
);

  localparam int MW   = mag_width(DATA_WIDTH);
  localparam int SW   = sum_width(DATA_WIDTH, LOG2_FILTER_LENGTH);
  localparam int FLEN = 1 << LOG2_FILTER_LENGTH;

  logic [DATA_WIDTH-1:0] abs_i;
  logic [DATA_WIDTH-1:0] abs_q;
  logic [MW-1:0]         mag_r;
  logic [MW-1:0]         hist [FLEN];
  logic [SW-1:0]         sum_r;
  logic [MW-1:0]         avg;
  logic [DATA_WIDTH-1:0] eff_off;

  // Negating in DATA_WIDTH bits is exact when read as unsigned, even for -2^(W-1).
  always_comb begin
    abs_i = data_i[DATA_WIDTH-1] ? (~data_i + DATA_WIDTH'(1)) : data_i;
    abs_q = data_q[DATA_WIDTH-1] ? (~data_q + DATA_WIDTH'(1)) : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_r <= '0;
    end else begin
      mag_r <= MW'(abs_i) + MW'(abs_q);
    end
  end

  // Running sum: add the newest magnitude, drop the one leaving the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      for (int k = 0; k < FLEN; k++) begin
        hist[k] <= '0;
      end
    end else begin
      sum_r   <= sum_r + SW'(mag_r) - SW'(hist[FLEN-1]);
      hist[0] <= mag_r;
      for (int k = 1; k < FLEN; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  always_comb begin
    avg     = sum_r[SW-1:LOG2_FILTER_LENGTH];
    eff_off = (thresh_off < thresh_on) ? thresh_off : thresh_on;
    above   = (avg > MW'(thresh_on));
    below   = (avg < MW'(eff_off));
  end

endmodule

// File: rtl/ad9361_samp_gate.sv
// Multi-channel energy-gated sample filter for the AD9361 receive path.
// Define SAMP_GATE_COMMON_EN to drive every channel from one shared gate FSM.
module ad9361_samp_gate
  import ad9361_samp_gate_pkg::*;
#(
  parameter int NUM_CHANNELS       = 4,
  parameter int DATA_WIDTH         = 12,
  parameter int NUM_DELAY          = 24,
  parameter int NUM_PAD_SAMPS      = 7,
  parameter int LOG2_FILTER_LENGTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            valid_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q_in,
  input  logic [DATA_WIDTH-1:0]              thresh_on,
  input  logic [DATA_WIDTH-1:0]              thresh_off,
  input  logic                               bypass,
  output logic [NUM_CHANNELS-1:0]            valid_out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i_out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q_out,
  output logic [NUM_CHANNELS-1:0]            gate_open
);

`ifdef SAMP_GATE_COMMON_EN
  localparam int NUM_FSM = 1;
`else
  localparam int NUM_FSM = NUM_CHANNELS;
`endif
  localparam int CW  = NUM_CHANNELS * DATA_WIDTH;
  localparam int HCW = (NUM_PAD_SAMPS > 0) ? $clog2(NUM_PAD_SAMPS + 1) : 1;
  localparam logic [HCW-1:0] HANG_LOAD = (NUM_PAD_SAMPS > 0) ? HCW'(NUM_PAD_SAMPS - 1) : '0;

  logic [NUM_CHANNELS-1:0] above;
  logic [NUM_CHANNELS-1:0] below;
  logic [NUM_FSM-1:0]      fsm_trig;
  logic [NUM_FSM-1:0]      fsm_rel;
  gate_state_t             state     [NUM_FSM];
  gate_state_t             state_nxt [NUM_FSM];
  logic [HCW-1:0]          hang_cnt  [NUM_FSM];
  logic [HCW-1:0]          hang_nxt  [NUM_FSM];
  logic [CW-1:0]           dly_i     [NUM_DELAY];
  logic [CW-1:0]           dly_q     [NUM_DELAY];
  logic [NUM_CHANNELS-1:0] dly_v     [NUM_DELAY];
  logic [NUM_CHANNELS-1:0] ch_open;

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_det
    ad9361_samp_gate_det #(
      .DATA_WIDTH         (DATA_WIDTH),
      .LOG2_FILTER_LENGTH (LOG2_FILTER_LENGTH)
    ) u_det (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_i     (data_i_in[n*DATA_WIDTH +: DATA_WIDTH]),
      .data_q     (data_q_in[n*DATA_WIDTH +: DATA_WIDTH]),
      .thresh_on  (thresh_on),
      .thresh_off (thresh_off),
      .above      (above[n]),
      .below      (below[n])
    );
  end

  // Shared gate opens on any channel and releases only once all channels are quiet.
`ifdef SAMP_GATE_COMMON_EN
  assign fsm_trig = |above;
  assign fsm_rel  = &below;
`else
  assign fsm_trig = above;
  assign fsm_rel  = below;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FSM; f++) begin
        state[f]    <= IDLE;
        hang_cnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NUM_FSM; f++) begin
        state[f]    <= state_nxt[f];
        hang_cnt[f] <= hang_nxt[f];
      end
    end
  end

  // A trigger during HANG wins over expiry so the gate never blinks closed.
  always_comb begin
    for (int f = 0; f < NUM_FSM; f++) begin
      state_nxt[f] = state[f];
      hang_nxt[f]  = hang_cnt[f];
      case (state[f])
        IDLE: begin
          if (fsm_trig[f]) begin
            state_nxt[f] = OPEN;
          end
        end
        OPEN: begin
          if (fsm_rel[f]) begin
            if (NUM_PAD_SAMPS == 0) begin
              state_nxt[f] = IDLE;
            end else begin
              state_nxt[f] = HANG;
              hang_nxt[f]  = HANG_LOAD;
            end
          end
        end
        HANG: begin
          if (fsm_trig[f]) begin
            state_nxt[f] = OPEN;
          end else if (hang_cnt[f] == '0) begin
            state_nxt[f] = IDLE;
          end else begin
            hang_nxt[f] = hang_cnt[f] - HCW'(1);
          end
        end
        default: begin
          state_nxt[f] = IDLE;
          hang_nxt[f]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DELAY; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
        dly_v[k] <= '0;
      end
    end else begin
      dly_i[0] <= data_i_in;
      dly_q[0] <= data_q_in;
      dly_v[0] <= valid_in;
      for (int k = 1; k < NUM_DELAY; k++) begin
        dly_i[k] <= dly_i[k-1];
        dly_q[k] <= dly_q[k-1];
        dly_v[k] <= dly_v[k-1];
      end
    end
  end

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_open
    assign ch_open[n] = (state[(NUM_FSM == 1) ? 0 : n] != IDLE);
  end

  // The last delay stage is the output register; the gate only masks valid.
  assign data_i_out = dly_i[NUM_DELAY-1];
  assign data_q_out = dly_q[NUM_DELAY-1];
  assign valid_out  = dly_v[NUM_DELAY-1] & ({NUM_CHANNELS{bypass}} | ch_open);
  assign gate_open  = ch_open;

endmodule
